// File: rtl/divisor_frec_param.sv
// Cascaded tick generator: programmable prescaler, then mod-RADIX stages, one TICK/SQ pair per tap.
// Latency: TICK is registered one cycle after the terminal count, and all taps are aligned.
// Backpressure: none. EN freezes counting. DIVISOR_DIGIT_OUT_EN adds the DIGITS port.
module divisor_frec_param #(
    parameter int DIV_W       = 17,
    parameter int DEFAULT_DIV = 100000,
    parameter int N_STAGES    = 3,
    parameter int RADIX       = 10,
    parameter int DIGIT_W     = $clog2(RADIX)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic                CLR,
    input  logic [DIV_W-1:0]    DIV,
    input  logic                DIV_LD,
    output logic                LD_PEND,
    output logic [N_STAGES-1:0] TICK,
    output logic [N_STAGES-1:0] SQ
`ifdef DIVISOR_DIGIT_OUT_EN
    ,
    output logic [(N_STAGES-1)*DIGIT_W-1:0] DIGITS
`endif
);

    // Stage k (k >= 1) lives in dcnt_q[k-1]. One dummy slot is kept when N_STAGES == 1.
    localparam int DCNT_N = (N_STAGES > 1) ? N_STAGES - 1 : 1;
    localparam logic [DIV_W-1:0]   DEF_RATIO  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(RADIX - 1);

    logic [DIV_W-1:0]    pcnt_q;
    logic [DIV_W-1:0]    div_act_q;
    logic [DIV_W-1:0]    shadow_q;
    logic                ld_pend_q;
    logic [DIGIT_W-1:0]  dcnt_q [DCNT_N];
    logic [N_STAGES-1:0] tick_q;
    logic [N_STAGES-1:0] sq_q;

    logic [DIV_W-1:0]    div_eff;
    logic [DIV_W-1:0]    pcnt_last;
    logic [N_STAGES-1:0] tc;

    always_comb begin
        div_eff   = (div_act_q == '0) ? DIV_W'(1) : div_act_q;
        pcnt_last = div_eff - DIV_W'(1);
        tc        = '0;
        tc[0]     = EN & (pcnt_q == pcnt_last);
        for (int k = 1; k < N_STAGES; k++) begin
            tc[k] = tc[k-1] & (dcnt_q[k-1] == LAST_DIGIT);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pcnt_q    <= '0;
            div_act_q <= DEF_RATIO;
            shadow_q  <= DEF_RATIO;
            ld_pend_q <= 1'b0;
            tick_q    <= '0;
            sq_q      <= '0;
            for (int k = 0; k < DCNT_N; k++) begin
                dcnt_q[k] <= '0;
            end
        end else begin
            if (CLR) begin
                pcnt_q    <= '0;
                tick_q    <= '0;
                sq_q      <= '0;
                div_act_q <= shadow_q;
                ld_pend_q <= 1'b0;
                for (int k = 0; k < DCNT_N; k++) begin
                    dcnt_q[k] <= '0;
                end
            end else begin
                tick_q <= tc;
                sq_q   <= sq_q ^ tc;
                if (EN) begin
                    pcnt_q <= tc[0] ? '0 : pcnt_q + DIV_W'(1);
                    for (int k = 1; k < N_STAGES; k++) begin
                        if (tc[k]) begin
                            dcnt_q[k-1] <= '0;
                        end else if (tc[k-1]) begin
                            dcnt_q[k-1] <= dcnt_q[k-1] + DIGIT_W'(1);
                        end
                    end
                end
                // The new ratio takes effect only on a tick boundary, or right away while the counters are frozen.
                if (ld_pend_q && (tc[0] || !EN)) begin
                    div_act_q <= shadow_q;
                    pcnt_q    <= '0;
                    ld_pend_q <= 1'b0;
                end
            end
            // A fresh capture always stays pending, even when an older value is applied on this edge.
            if (DIV_LD) begin
                shadow_q  <= DIV;
                ld_pend_q <= 1'b1;
            end
        end
    end

    assign TICK    = tick_q;
    assign SQ      = sq_q;
    assign LD_PEND = ld_pend_q;

`ifdef DIVISOR_DIGIT_OUT_EN
    always_comb begin
        DIGITS = '0;
        for (int k = 0; k < N_STAGES - 1; k++) begin
            DIGITS[k*DIGIT_W +: DIGIT_W] = dcnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_divisor_frec_param.sv
// Directed bench for divisor_frec_param with DEFAULT_DIV=4, N_STAGES=3, RADIX=10.
module tb_divisor_frec_param;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic        CLR;
    logic [16:0] DIV;
    logic        DIV_LD;
    logic        LD_PEND;
    logic [2:0]  TICK;
    logic [2:0]  SQ;
`ifdef DIVISOR_DIGIT_OUT_EN
    logic [7:0]  DIGITS;
`endif

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [2:0] esq    = 3'b000;

    divisor_frec_param #(
        .DIV_W(17), .DEFAULT_DIV(4), .N_STAGES(3), .RADIX(10)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .DIV(DIV), .DIV_LD(DIV_LD),
        .LD_PEND(LD_PEND), .TICK(TICK), .SQ(SQ)
`ifdef DIVISOR_DIGIT_OUT_EN
        , .DIGITS(DIGITS)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock edge, then compare TICK, SQ and LD_PEND. Expected SQ toggles on each expected TICK.
    task automatic step(input logic [2:0] et, input logic ep);
        @(posedge CLK);
        #1;
        cyc++;
        esq = esq ^ et;
        chk("tick", {29'd0, TICK}, {29'd0, et});
        chk("sq", {29'd0, SQ}, {29'd0, esq});
        chk("ld_pend", {31'd0, LD_PEND}, {31'd0, ep});
    endtask

    initial begin
        logic [2:0] et;
        RST = 1'b0; EN = 1'b0; CLR = 1'b0; DIV = '0; DIV_LD = 1'b0;
        #1;
        chk("rst_tick", {29'd0, TICK}, 32'd0);
        chk("rst_sq", {29'd0, SQ}, 32'd0);
        chk("rst_pend", {31'd0, LD_PEND}, 32'd0);
        @(posedge CLK);
        #1;
        chk("rst_hold_tick", {29'd0, TICK}, 32'd0);
        RST = 1'b1;
        EN  = 1'b1;

        // Default ratio 4: TICK0 every 4, TICK1 every 40, TICK2 every 400
        for (int c = 1; c <= 400; c++) begin
            et[0] = (c % 4 == 0);
            et[1] = (c % 40 == 0);
            et[2] = (c % 400 == 0);
            step(et, 1'b0);
`ifdef DIVISOR_DIGIT_OUT_EN
            if (c == 36) chk("digits_9", {24'd0, DIGITS}, 32'h09);
            if (c == 40) chk("digits_carry", {24'd0, DIGITS}, 32'h10);
`endif
        end

        // CLR with stage 1 at 5
        for (int j = 1; j <= 22; j++) step({2'b00, j % 4 == 0}, 1'b0);
        CLR = 1'b1;
        esq = 3'b000;
        step(3'b000, 1'b0);
        CLR = 1'b0;
        for (int j = 1; j <= 40; j++) step({1'b0, j == 40, j % 4 == 0}, 1'b0);

        // EN low for 7 cycles mid-period
        step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        EN = 1'b0;
        for (int j = 1; j <= 7; j++) step(3'b000, 1'b0);
        EN = 1'b1;
        step(3'b000, 1'b0);
        step(3'b001, 1'b0);

        // Ratio 6 loaded mid-period, applied at the next tick
        DIV = 17'd6; DIV_LD = 1'b1;
        step(3'b000, 1'b1);
        DIV_LD = 1'b0;
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);
        step(3'b001, 1'b0);
        for (int j = 1; j <= 48; j++) step({1'b0, j == 48, j % 6 == 0}, 1'b0);

        // Load coinciding with a tick: 3 is applied there, 2 stays pending
        DIV = 17'd3; DIV_LD = 1'b1;
        step(3'b000, 1'b1);
        DIV_LD = 1'b0;
        for (int j = 1; j <= 4; j++) step(3'b000, 1'b1);
        DIV = 17'd2; DIV_LD = 1'b1;
        step(3'b001, 1'b1);
        DIV_LD = 1'b0;
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);
        step(3'b001, 1'b0);
        step(3'b000, 1'b0);
        step(3'b001, 1'b0);

        // Load together with CLR: CLR applies 4, 7 stays pending
        DIV = 17'd4; DIV_LD = 1'b1;
        step(3'b000, 1'b1);
        CLR = 1'b1; DIV = 17'd7;
        esq = 3'b000;
        step(3'b000, 1'b1);
        CLR = 1'b0; DIV_LD = 1'b0;
        for (int j = 1; j <= 3; j++) step(3'b000, 1'b1);
        step(3'b001, 1'b0);
        for (int j = 1; j <= 6; j++) step(3'b000, 1'b0);
        step(3'b001, 1'b0);

        // Ratio 0 behaves as 1
        DIV = 17'd0; DIV_LD = 1'b1;
        step(3'b000, 1'b1);
        DIV_LD = 1'b0;
        for (int j = 1; j <= 5; j++) step(3'b000, 1'b1);
        step(3'b001, 1'b0);
        for (int j = 1; j <= 27; j++) step({1'b0, j % 10 == 7, 1'b1}, 1'b0);

        // Ratio 1
        DIV = 17'd1;
        for (int j = 1; j <= 20; j++) begin
            DIV_LD = (j == 1);
            step({1'b0, j % 10 == 0, 1'b1}, j == 1);
        end
        DIV_LD = 1'b0;

        // Asynchronous reset while a load is pending
        DIV = 17'd9; DIV_LD = 1'b1;
        step(3'b001, 1'b1);
        DIV_LD = 1'b0;
        #2;
        RST = 1'b0;
        #1;
        chk("arst_tick", {29'd0, TICK}, 32'd0);
        chk("arst_sq", {29'd0, SQ}, 32'd0);
        chk("arst_pend", {31'd0, LD_PEND}, 32'd0);
        #1;
        RST = 1'b1;
        esq = 3'b000;
        for (int j = 1; j <= 8; j++) step({2'b00, j % 4 == 0}, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divisor_frec_param.md
Name: divisor_frec_param

Overview:
- Parametrised cascaded tick generator; successor to the fixed two-output frequency divider in the millisecond counter.
- A runtime-programmable prescaler divides CLK down to a base tick (1 ms at 100 MHz by default).
- A chain of mod-RADIX stages then produces slower ticks (10 ms, 100 ms, ...).
- Each tap provides a one-cycle TICK pulse and a 50% square-wave SQ output. These feed the digit counters and display refresh.

Parameters:
- DIV_W, 17, prescaler counter and DIV input width
- DEFAULT_DIV, 100000, prescaler ratio after reset (1 kHz from 100 MHz)
- N_STAGES, 3, number of taps (tap 0 = prescaler, taps 1..N_STAGES-1 = mod-RADIX stages); legal range 1..8
- RADIX, 10, modulus of each cascade stage; legal range 2..16
- DIGIT_W, $clog2(RADIX), derived; stage counter width

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-low
- EN  in  1  count enable
- CLR  in  1  synchronous clear
- DIV  in  DIV_W  new prescaler ratio
- DIV_LD  in  1  one-cycle strobe; captures DIV into the shadow register
- LD_PEND  out  1  high while a captured ratio has not yet been applied
- TICK  out  N_STAGES  one-cycle pulse per tap
- SQ  out  N_STAGES  square wave per tap; toggles on each TICK of the same tap

Behaviour:
- Reset (RST=0, asynchronous):
  - prescaler count=0, all stage counts=0
  - div_act=DEFAULT_DIV, shadow=DEFAULT_DIV
  - LD_PEND=0, TICK=0, SQ=0
- Effective ratio: div_eff = (div_act==0) ? 1 : div_act. Prescaler counts 0..div_eff-1.
- Terminal conditions, combinational within the cycle:
  - tc0 = EN & (pcnt==div_eff-1)
  - tc_k = tc_{k-1} & (dcnt_k==RADIX-1) for k>=1
- Registered outputs: TICK[k] <= tc_k. This gives one cycle of latency from the terminal count, and all taps are aligned, so TICK[k] is always coincident with TICK[k-1].
- Counter updates:
  - on tc0, pcnt <= 0, else pcnt+1 when EN
  - dcnt_k increments when tc_{k-1}, and wraps RADIX-1 -> 0 when tc_k
- Tick periods: TICK[0] every div_eff cycles; TICK[k] every div_eff*RADIX^k cycles.
- SQ[k] <= ~SQ[k] on tc_k, so the SQ period is twice the TICK period.
- EN=0: all counters freeze, TICK=0, SQ holds its value.
- CLR=1 (priority over EN):
  - all counters, TICK and SQ go to 0 next cycle
  - a pending load is applied: div_act <= shadow, LD_PEND <= 0
- Ratio load:
  - DIV_LD=1 captures DIV into shadow and sets LD_PEND=1 next cycle. A later DIV_LD overwrites shadow; the last one wins.
  - The pending value is applied at the next tc0 (div_act <= shadow, pcnt <= 0, LD_PEND <= 0), so the period change happens only on a tick boundary.
  - If EN=0, the value is applied on the next cycle instead.
  - DIV_LD in the same cycle as tc0: the new DIV is captured and stays pending until the following tc0. The shadow value in place before that edge is applied.
  - DIV_LD together with CLR: CLR applies the old shadow. The new DIV is captured and stays pending.
- Wrap-around: when the last stage wraps, all dcnt return to 0 and counting continues; no overflow flag.
- div_eff=1: tc0 is true every enabled cycle and TICK[0] stays high continuously while EN=1.

Optional Feature:
- Macro: DIVISOR_DIGIT_OUT_EN
- Defined: adds output port DIGITS, width (N_STAGES-1)*DIGIT_W, which exposes dcnt_1..dcnt_{N_STAGES-1} (stage 1 in the LSBs). Values are registered and update in the same cycle as the matching TICK, for direct BCD display.
- Undefined: the port is absent and the digit counters remain internal. TICK and SQ behaviour is identical in both builds.

Test Plan:
- Reset with DEFAULT_DIV=4, N_STAGES=3, RADIX=10; release RST, EN=1 -> TICK[0] every 4 cycles, first pulse 4 cycles after release; TICK[1] every 40; TICK[2] every 400; SQ[0] period 8.
- Mid-run DIV=6 with DIV_LD pulse -> LD_PEND=1 until the next TICK[0] boundary; then TICK[0] spacing becomes 6; no short or long period in between.
- EN low for 7 cycles mid-count -> TICK=0 and SQ holds during the gap; the next TICK[0] is delayed by exactly 7 cycles.
- CLR while dcnt_1=5 -> next cycle all counts, TICK and SQ are 0; the next TICK[1] arrives 40 cycles later.
- DIV=0 and DIV=1 loads -> TICK[0] high on every enabled cycle; TICK[1] every 10 cycles.
- RST asserted asynchronously mid-period, including during LD_PEND=1 -> outputs go to 0 immediately, LD_PEND=0, and the ratio reverts to DEFAULT_DIV.
- With DIVISOR_DIGIT_OUT_EN defined -> DIGITS steps 0..9 on stage 1 and carries into stage 2 on the 10th TICK[1].
